// File: rtl/rrf_multiport.sv
// rrf_multiport: multi-ported rename register file.
// Each entry holds a data word and a valid bit. Forward (writeback) ports
// write data and set valid, allocate ports clear valid, flush clears all
// valid bits. Read and commit ports are combinational from the array.
// Optional feature macro: RRF_FWD_BYPASS_EN (same-cycle forward bypass on
// read and commit ports).
module rrf_multiport #(
   parameter int DEPTH     = 64,
   parameter int DATA_LEN  = 32,
   parameter int NUM_RD    = 4,
   parameter int NUM_FWD   = 2,
   parameter int NUM_ALLOC = 2,
   parameter int NUM_CMT   = 2,
   localparam int SEL      = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_RD*SEL-1:0]         rd_tag_i,
   output logic [NUM_RD*DATA_LEN-1:0]    rd_data_o,
   output logic [NUM_RD-1:0]             rd_valid_o,
   input  logic [NUM_FWD-1:0]            fwd_we_i,
   input  logic [NUM_FWD*SEL-1:0]        fwd_tag_i,
   input  logic [NUM_FWD*DATA_LEN-1:0]   fwd_data_i,
   input  logic [NUM_ALLOC-1:0]          alloc_en_i,
   input  logic [NUM_ALLOC*SEL-1:0]      alloc_tag_i,
   input  logic [NUM_CMT*SEL-1:0]        cmt_tag_i,
   output logic [NUM_CMT*DATA_LEN-1:0]   cmt_data_o,
   input  logic                          flush_i,
   output logic [SEL:0]                  valid_cnt_o,
   output logic                          collide_o,
   input  logic                          collide_clr_i
);

   logic [DATA_LEN-1:0] data_q [DEPTH];
   logic [DATA_LEN-1:0] data_n [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [DEPTH-1:0]    valid_n;
   logic [SEL:0]        cnt_q;
   logic [SEL:0]        cnt_n;
   logic                collide_q;
   logic                collide_set;

   // Next array state: forwards (lowest port applied last so it wins),
   // then allocates clear valid, then flush clears everything.
   always_comb begin
      logic [SEL-1:0] tag;
      data_n      = data_q;
      valid_n     = valid_q;
      collide_set = 1'b0;
      cnt_n       = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         tag = fwd_tag_i[k*SEL +: SEL];
         if (fwd_we_i[k] && !flush_i) begin
            data_n[tag]  = fwd_data_i[k*DATA_LEN +: DATA_LEN];
            valid_n[tag] = 1'b1;
         end
      end
      for (int k = 0; k < NUM_FWD; k++) begin
         for (int m = k + 1; m < NUM_FWD; m++) begin
            if (fwd_we_i[k] && fwd_we_i[m] &&
                (fwd_tag_i[k*SEL +: SEL] == fwd_tag_i[m*SEL +: SEL]))
               collide_set = 1'b1;
         end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
         tag = alloc_tag_i[j*SEL +: SEL];
         if (alloc_en_i[j])
            valid_n[tag] = 1'b0;
      end
      if (flush_i)
         valid_n = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_n = cnt_n + {{SEL{1'b0}}, valid_n[i]};
   end

   // Array, population count and sticky collision flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q    <= '{default: '0};
         valid_q   <= '0;
         cnt_q     <= '0;
         collide_q <= 1'b0;
      end else begin
         data_q  <= data_n;
         valid_q <= valid_n;
         cnt_q   <= cnt_n;
         if (collide_set)
            collide_q <= 1'b1;
         else if (collide_clr_i)
            collide_q <= 1'b0;
      end
   end

   // Source read ports, optionally bypassing same-cycle forward data.
   always_comb begin
      logic [SEL-1:0] tag;
      logic           alloc_hit;
      rd_data_o  = '0;
      rd_valid_o = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         tag       = rd_tag_i[i*SEL +: SEL];
         alloc_hit = 1'b0;
         rd_data_o[i*DATA_LEN +: DATA_LEN] = data_q[tag];
         rd_valid_o[i]                     = valid_q[tag];
`ifdef RRF_FWD_BYPASS_EN
         for (int j = 0; j < NUM_ALLOC; j++)
            if (alloc_en_i[j] && (alloc_tag_i[j*SEL +: SEL] == tag))
               alloc_hit = 1'b1;
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (reset && fwd_we_i[k] && (fwd_tag_i[k*SEL +: SEL] == tag)) begin
               rd_data_o[i*DATA_LEN +: DATA_LEN] = fwd_data_i[k*DATA_LEN +: DATA_LEN];
               rd_valid_o[i]                     = !flush_i && !alloc_hit;
            end
         end
`else
         alloc_hit = 1'b0;
`endif
      end
   end

   // Commit read ports toward the architectural register file.
   always_comb begin
      logic [SEL-1:0] tag;
      cmt_data_o = '0;
      for (int i = 0; i < NUM_CMT; i++) begin
         tag = cmt_tag_i[i*SEL +: SEL];
         cmt_data_o[i*DATA_LEN +: DATA_LEN] = data_q[tag];
`ifdef RRF_FWD_BYPASS_EN
         for (int k = NUM_FWD - 1; k >= 0; k--)
            if (reset && fwd_we_i[k] && (fwd_tag_i[k*SEL +: SEL] == tag))
               cmt_data_o[i*DATA_LEN +: DATA_LEN] = fwd_data_i[k*DATA_LEN +: DATA_LEN];
`endif
      end
   end

   assign valid_cnt_o = cnt_q;
   assign collide_o   = collide_q;

endmodule
